// File: rtl/fib_index_fsm_if.sv
// Start/busy/done request bus for fib_index_fsm; zmask and ZW exist only when ZECK_EN is defined.
interface fib_index_fsm_if #(
    parameter int W = 32
`ifdef ZECK_EN
    , parameter int ZW = 50
`endif
);
    logic         start;
    logic [W-1:0] x;
    logic         busy;
    logic         done;
    logic [W-1:0] n;
    logic [W-1:0] fn;
    logic         exact;
`ifdef ZECK_EN
    logic [ZW-1:0] zmask;

    modport master (output start, x, input busy, done, n, fn, exact, zmask);
    modport slave  (input start, x, output busy, done, n, fn, exact, zmask);
`else
    modport master (output start, x, input busy, done, n, fn, exact);
    modport slave  (input start, x, output busy, done, n, fn, exact);
`endif
endinterface

// File: rtl/fib_index_fsm.sv
// Finds largest n with fib(n) <= x; done in cycle n (cycle 1 for x=0), plus descent cycles under ZECK_EN.
// Start is ignored while busy; optional ZECK_EN adds a greedy descent that emits the Zeckendorf mask.
module fib_index_fsm #(
    parameter int W = 32
`ifdef ZECK_EN
    , parameter int ZW = 50
`endif
) (
    input  logic           clk,
    input  logic           rst,
    fib_index_fsm_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ASCEND  = 2'b01,
`ifdef ZECK_EN
        DESCEND = 2'b10,
`endif
        DONE    = 2'b11
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] xr_q, xr_d;
    logic [W-1:0] p_q, p_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] k_q, k_d;
    logic [W-1:0] n_q, n_d;
    logic [W-1:0] fn_q, fn_d;
    logic         exact_q, exact_d;
    logic [W:0]   s;
`ifdef ZECK_EN
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  r_sub;
    logic [ZW-1:0] zmask_q, zmask_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xr_q    <= '0;
            p_q     <= '0;
            q_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            fn_q    <= '0;
            exact_q <= 1'b0;
`ifdef ZECK_EN
            r_q     <= '0;
            zmask_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            p_q     <= p_d;
            q_q     <= q_d;
            k_q     <= k_d;
            n_q     <= n_d;
            fn_q    <= fn_d;
            exact_q <= exact_d;
`ifdef ZECK_EN
            r_q     <= r_d;
            zmask_q <= zmask_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        p_d     = p_q;
        q_d     = q_q;
        k_d     = k_q;
        n_d     = n_q;
        fn_d    = fn_q;
        exact_d = exact_q;
`ifdef ZECK_EN
        r_d     = r_q;
        r_sub   = r_q;
        zmask_d = zmask_q;
`endif
        // Extra carry bit: a sum that overflows W bits ends the climb instead of wrapping.
        s = {1'b0, p_q} + {1'b0, q_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.x == '0) begin
                        n_d     = '0;
                        fn_d    = '0;
                        exact_d = 1'b1;
`ifdef ZECK_EN
                        zmask_d = '0;
`endif
                        state_d = DONE;
                    end else begin
                        xr_d    = bus.x;
                        p_d     = W'(1);
                        q_d     = W'(1);
                        k_d     = W'(2);
                        state_d = ASCEND;
                    end
                end
            end
            ASCEND: begin
                if (!s[W] && (s[W-1:0] <= xr_q)) begin
                    p_d = q_q;
                    q_d = s[W-1:0];
                    k_d = k_q + W'(1);
                end else begin
                    n_d     = k_q;
                    fn_d    = q_q;
                    exact_d = (q_q == xr_q);
`ifdef ZECK_EN
                    r_d     = xr_q;
                    zmask_d = '0;
                    state_d = DESCEND;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef ZECK_EN
            DESCEND: begin
                if (q_q <= r_q) begin
                    zmask_d = zmask_q | (ZW'(1) << (k_q - W'(2)));
                    r_sub   = r_q - q_q;
                end
                r_d = r_sub;
                // Walk the pair back down: (p, q) = (fib(k-2), fib(k-1)).
                q_d = p_q;
                p_d = q_q - p_q;
                k_d = k_q - W'(1);
                if ((k_q == W'(2)) || (r_sub == '0)) begin
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.n     = n_q;
    assign bus.fn    = fn_q;
    assign bus.exact = exact_q;
`ifdef ZECK_EN
    assign bus.zmask = zmask_q;
`endif
endmodule
